lsu_dport: RTL and testbench
============================

# lsu_dport

Load/store access unit for the data side of the core. Accepts one load or store request from the MEM stage, checks alignment and address range, and drives the byte-addressed data RAM port (`adr`/`op`/`we`/`wdin` out, `rdo` in). It returns sign- or zero-extended load data, or a precise exception cause and bad address, through a registered response. It is the initiator end of the data RAM interface and the only block that drives that RAM.

## Interface
- `MEM_BASE`, default 32'h0000_0000: byte address mapped to RAM offset 0.
- `MEM_BYTES`, default 1024: RAM size in bytes; offsets at or above this fault.
- `clk` in 1: clock; all state updates on posedge.
- `rst_n` in 1: asynchronous, active-low reset.
- `flush` in 1: synchronous abort from the exception/interrupt unit.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3 (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
- `req_addr` in 32: effective byte address.
- `req_wdata` in 32: store data, LSB-aligned.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out 32: extended load data; 0 for stores and exceptions.
- `resp_exc` out 1: response carries an exception.
- `resp_cause` out 4: cause code 2 (illegal funct3), 4 (load misaligned), 5 (load access fault), 6 (store misaligned), or 7 (store access fault).
- `resp_badaddr` out 32: `req_addr` of a faulting request, else 0.
- `mem_adr` out 32: RAM byte offset (`req_addr - MEM_BASE`).
- `mem_op` out 2: `W_B`/`W_H`/`W_W` from core/defines.v.
- `mem_we` out 1: RAM write enable.
- `mem_wdin` out 32: RAM write data.
- `mem_rdo` in 32: RAM read data, combinational from `mem_adr`; byte at `mem_adr` is in [7:0].

## Operation
- The FSM has three states:
  - IDLE: `req_ready`=1.
  - ACCESS: `req_ready`=0.
  - RESP: `req_ready`=1, `resp_valid`=1.
- Accept occurs when `req_valid && req_ready` at a posedge. The accept latches we, funct3, addr, wdata and the computed size (1, 2 or 4 bytes).
- Checks run on the request at accept. The first matching check applies:
  1. Illegal funct3 (load not in {0,1,2,4,5}; store not in {0,1,2}) gives cause 2.
  2. Misaligned (half with `addr[0]`; word with `addr[1:0]`≠0) gives cause 4 or 6.
  3. Out of range (`addr < MEM_BASE` or `addr - MEM_BASE > MEM_BYTES - size`) gives cause 5 or 7. The subtraction is unsigned 32-bit, so wrap counts as a fault.
- A faulting request goes directly to RESP with `resp_exc`=1. `mem_we` is never asserted for it.
- A clean request goes to ACCESS, then to RESP.
- In ACCESS:
  - `mem_we` = store && !`flush`, combinational.
  - `mem_adr`/`mem_op`/`mem_wdin` come from latched values. They hold their last values in every other state.
- A load captures `mem_rdo` at the posedge that ends ACCESS and extends it:
  - funct3 0: sign-extend [7:0].
  - funct3 1: sign-extend [15:0].
  - funct3 2: pass [31:0].
  - funct3 4: zero-extend [7:0].
  - funct3 5: zero-extend [15:0].
- RESP lasts one cycle. A new request accepted in RESP goes to ACCESS or RESP as above. With no new request, the FSM returns to IDLE.
- `flush` forces IDLE at the next posedge from any state and has the highest priority.
  - `resp_valid` is gated low during any cycle with `flush`=1.
  - A request presented with `flush`=1 is not accepted (`req_ready`=0).

## Timing
- Reset (async, `rst_n`=0): state IDLE. `req_ready`=1 after state settles. All of the following are 0: `resp_valid`, `resp_exc`, `resp_cause`, `resp_rdata`, `resp_badaddr`, `mem_adr`, `mem_op`, `mem_we`, `mem_wdin`.
- Clean access:
  - Accepted at edge N.
  - ACCESS during cycle N..N+1.
  - Store written into the RAM at edge N+1.
  - `resp_valid` high during cycle N+1..N+2.
  - Latency 2 cycles; throughput 1 request per 2 cycles.
- Faulting access: `resp_valid` high during cycle N..N+1. Latency 1.
- Reset asserted mid-ACCESS: `mem_we` drops immediately (asynchronously), no response is produced, and the FSM restarts in IDLE.
- `resp_*` fields are registered and stable for the whole RESP cycle. Outside RESP they are don't-care except `resp_valid`=0.

## Test plan
- After reset: SW addr 0x10, data 0xDEADBEEF; then LW 0x10. Required: `mem_we`=1 for exactly one cycle with `mem_op`=`W_W`; load `resp_rdata`=0xDEADBEEF two cycles after accept.
- Extension: LB, LBU, LH, LHU at 0x13, 0x13, 0x12, 0x12 after the store above. Required: 0xFFFFFFDE, 0x000000DE, 0xFFFFDEAD, 0x0000DEAD.
- Misalignment: LH 0x21 and SW 0x22. Required: one-cycle response with cause 4, then cause 6, `resp_badaddr` 0x21 and 0x22, `mem_we` never 1.
- Range and funct3: LW 0x3FC is OK; LW 0x400 gives cause 5; SW 0xFFFFFFFC gives cause 7; load funct3 3 gives cause 2.
- Flush: SB 0x40 of 0xAA with `flush`=1 during ACCESS. Required: no write (later LBU 0x40 returns 0), no `resp_valid`, back-to-back request accepted the following cycle.
- Async reset mid-ACCESS of a store. Required: `mem_we` low within the reset cycle, no response, `req_ready`=1 after release.

Source files
------------

// File: rtl/lsu_dport_if.sv
// Data-side load/store port bundle: MEM-stage request, registered response,
// and the byte-addressed data RAM port. The LSU uses the slave modport.
interface lsu_dport_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_exc;
  logic [3:0]  resp_cause;
  logic [31:0] resp_badaddr;
  logic [31:0] mem_adr;
  logic [1:0]  mem_op;
  logic        mem_we;
  logic [31:0] mem_wdin;
  logic [31:0] mem_rdo;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdo,
    output req_ready, resp_valid, resp_rdata, resp_exc, resp_cause, resp_badaddr,
           mem_adr, mem_op, mem_we, mem_wdin
  );
  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdo,
    input  req_ready, resp_valid, resp_rdata, resp_exc, resp_cause, resp_badaddr,
           mem_adr, mem_op, mem_we, mem_wdin
  );
endinterface

// File: rtl/lsu_dport.sv
// Load/store access unit: checks funct3/alignment/range at accept, drives the
// data RAM for one cycle, and returns extended load data or a precise fault.
module lsu_dport #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter int          MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  lsu_dport_if.slave  bus
);
  localparam logic [1:0]  W_B = 2'd0, W_H = 2'd1, W_W = 2'd2;
  localparam logic [31:0] MEM_BYTES_L = 32'(MEM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
  state_t r_state;

  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_adr, r_wdin, r_rdata, r_badaddr;
  logic [1:0]  r_op;
  logic        r_exc;
  logic [3:0]  r_cause;

  logic        w_ready, w_acc, w_illegal, w_mis, w_oor, w_fault;
  logic [2:0]  w_size;
  logic [1:0]  w_op;
  logic [3:0]  w_cause;
  logic [31:0] w_off, w_ext;

  assign w_ready = (r_state != S_ACCESS) && !flush;
  assign w_acc   = bus.req_valid && w_ready;

  always_comb begin
    w_size = 3'd4;
    w_op   = W_W;
    case (bus.req_funct3[1:0])
      2'd0: begin w_size = 3'd1; w_op = W_B; end
      2'd1: begin w_size = 3'd2; w_op = W_H; end
      default: ;
    endcase
  end

  // Check priority: funct3, then alignment, then range (offset wrap is a fault).
  assign w_illegal = bus.req_we ? (bus.req_funct3 > 3'd2)
                                : (bus.req_funct3 == 3'd3 || bus.req_funct3[2:1] == 2'b11);
  assign w_mis   = (bus.req_funct3[1:0] == 2'd1 && bus.req_addr[0]) ||
                   (bus.req_funct3[1:0] == 2'd2 && bus.req_addr[1:0] != 2'b00);
  assign w_off   = bus.req_addr - MEM_BASE;
  assign w_oor   = (bus.req_addr < MEM_BASE) || (w_off > (MEM_BYTES_L - {29'd0, w_size}));
  assign w_fault = w_illegal || w_mis || w_oor;
  assign w_cause = w_illegal ? 4'd2 :
                   w_mis     ? (bus.req_we ? 4'd6 : 4'd4) :
                               (bus.req_we ? 4'd7 : 4'd5);

  always_comb begin
    w_ext = bus.mem_rdo;
    case (r_f3)
      3'd0: w_ext = {{24{bus.mem_rdo[7]}},  bus.mem_rdo[7:0]};
      3'd1: w_ext = {{16{bus.mem_rdo[15]}}, bus.mem_rdo[15:0]};
      3'd4: w_ext = {24'd0, bus.mem_rdo[7:0]};
      3'd5: w_ext = {16'd0, bus.mem_rdo[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_f3      <= 3'd0;
      r_adr     <= 32'd0;
      r_op      <= 2'd0;
      r_wdin    <= 32'd0;
      r_rdata   <= 32'd0;
      r_exc     <= 1'b0;
      r_cause   <= 4'd0;
      r_badaddr <= 32'd0;
    end else if (flush) begin
      r_state <= S_IDLE;
    end else if (r_state == S_ACCESS) begin
      r_state   <= S_RESP;
      r_exc     <= 1'b0;
      r_cause   <= 4'd0;
      r_badaddr <= 32'd0;
      r_rdata   <= r_we ? 32'd0 : w_ext;
    end else if (w_acc) begin
      r_we <= bus.req_we;
      r_f3 <= bus.req_funct3;
      if (w_fault) begin
        r_state   <= S_RESP;
        r_exc     <= 1'b1;
        r_cause   <= w_cause;
        r_badaddr <= bus.req_addr;
        r_rdata   <= 32'd0;
      end else begin
        // RAM-side registers only move on a clean accept so they hold otherwise.
        r_state <= S_ACCESS;
        r_adr   <= w_off;
        r_op    <= w_op;
        r_wdin  <= bus.req_wdata;
      end
    end else begin
      r_state <= S_IDLE;
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.resp_valid   = (r_state == S_RESP) && !flush;
  assign bus.resp_rdata   = r_rdata;
  assign bus.resp_exc     = r_exc;
  assign bus.resp_cause   = r_cause;
  assign bus.resp_badaddr = r_badaddr;
  assign bus.mem_adr      = r_adr;
  assign bus.mem_op       = r_op;
  assign bus.mem_we       = (r_state == S_ACCESS) && r_we && !flush;
  assign bus.mem_wdin     = r_wdin;
endmodule

// File: tb/tb_lsu_dport.sv
// Directed bench for lsu_dport with a 1 KiB byte RAM model on the data port.
module tb_lsu_dport;
  localparam logic [1:0] W_B = 2'd0, W_H = 2'd1, W_W = 2'd2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  logic [7:0] ram [0:1023];
  logic [9:0] ra;

  lsu_dport_if bus();
  lsu_dport #(.MEM_BASE(32'h0), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus));

  always #5 clk = ~clk;

  assign ra = bus.mem_adr[9:0];
  assign bus.mem_rdo = {ram[ra + 10'd3], ram[ra + 10'd2], ram[ra + 10'd1], ram[ra]};

  always @(posedge clk) begin
    if (bus.mem_we) begin
      ram[ra] <= bus.mem_wdin[7:0];
      if (bus.mem_op != W_B) ram[ra + 10'd1] <= bus.mem_wdin[15:8];
      if (bus.mem_op == W_W) begin
        ram[ra + 10'd2] <= bus.mem_wdin[23:16];
        ram[ra + 10'd3] <= bus.mem_wdin[31:24];
      end
    end
  end

  // Issue one request from IDLE and observe until the response (bounded to 4 cycles).
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, wd,
                        output int lat, output int wecnt, output logic [1:0] op_seen,
                        output logic [31:0] rd, output logic exc, output logic [3:0] cause,
                        output logic [31:0] bad);
    lat = 0; wecnt = 0; op_seen = 2'd3; rd = 'x; exc = 'x; cause = 'x; bad = 'x;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_funct3 = f3;
    bus.req_addr = a; bus.req_wdata = wd;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    for (int i = 1; i <= 4 && lat == 0; i++) begin
      @(negedge clk);
      if (bus.mem_we) begin wecnt++; op_seen = bus.mem_op; end
      if (bus.resp_valid) begin
        lat = i; rd = bus.resp_rdata; exc = bus.resp_exc;
        cause = bus.resp_cause; bad = bus.resp_badaddr;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_chk++; if (bus.req_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.req_ready); else n_pass++;
    n_chk++;
    if ({bus.resp_valid, bus.resp_exc, bus.resp_cause, bus.resp_rdata, bus.resp_badaddr} !== '0 ||
        {bus.mem_adr, bus.mem_op, bus.mem_we, bus.mem_wdin} !== '0)
      $display("FAIL reset_outputs: got nonzero resp/mem outputs want all 0");
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_store_load();
    int lat, wc; logic [1:0] op; logic [31:0] rd, bad; logic exc; logic [3:0] c;
    do_req(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, lat, wc, op, rd, exc, c, bad);
    n_chk++; if (lat !== 2) $display("FAIL sw_latency: got %0d want 2", lat); else n_pass++;
    n_chk++; if (wc !== 1 || op !== W_W) $display("FAIL sw_we: got cnt %0d op %0d want cnt 1 op %0d", wc, op, W_W); else n_pass++;
    n_chk++; if (bus.mem_adr !== 32'h10 || bus.mem_wdin !== 32'hDEADBEEF) $display("FAIL sw_port: got adr %h wdin %h want 10 deadbeef", bus.mem_adr, bus.mem_wdin); else n_pass++;
    n_chk++; if (exc !== 1'b0 || rd !== 32'h0) $display("FAIL sw_resp: got exc %b rdata %h want 0 0", exc, rd); else n_pass++;
    do_req(1'b0, 3'd2, 32'h10, 32'h0, lat, wc, op, rd, exc, c, bad);
    n_chk++; if (lat !== 2 || rd !== 32'hDEADBEEF) $display("FAIL lw_data: got lat %0d rdata %h want 2 deadbeef", lat, rd); else n_pass++;
    n_chk++; if (wc !== 0) $display("FAIL lw_no_we: got %0d want 0", wc); else n_pass++;
  endtask

  task automatic test_extension();
    logic [2:0]  f3v [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
    logic [31:0] av  [4] = '{32'h13, 32'h13, 32'h12, 32'h12};
    logic [31:0] ev  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
    int lat, wc; logic [1:0] op; logic [31:0] rd, bad; logic exc; logic [3:0] c;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, f3v[i], av[i], 32'h0, lat, wc, op, rd, exc, c, bad);
      n_chk++; if (lat !== 2 || rd !== ev[i]) $display("FAIL ext_f3_%0d: got lat %0d rdata %h want 2 %h", f3v[i], lat, rd, ev[i]); else n_pass++;
    end
  endtask

  task automatic test_misalign();
    int lat, wc; logic [1:0] op; logic [31:0] rd, bad; logic exc; logic [3:0] c;
    do_req(1'b0, 3'd1, 32'h21, 32'h0, lat, wc, op, rd, exc, c, bad);
    n_chk++; if (lat !== 1 || exc !== 1'b1 || c !== 4'd4 || bad !== 32'h21 || wc !== 0)
      $display("FAIL lh_misalign: got lat %0d exc %b cause %0d bad %h we %0d want 1 1 4 21 0", lat, exc, c, bad, wc); else n_pass++;
    do_req(1'b1, 3'd2, 32'h22, 32'h5555AAAA, lat, wc, op, rd, exc, c, bad);
    n_chk++; if (lat !== 1 || exc !== 1'b1 || c !== 4'd6 || bad !== 32'h22 || wc !== 0)
      $display("FAIL sw_misalign: got lat %0d exc %b cause %0d bad %h we %0d want 1 1 6 22 0", lat, exc, c, bad, wc); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 1'b0) $display("FAIL fault_one_cycle: got resp_valid %b want 0", bus.resp_valid); else n_pass++;
  endtask

  task automatic test_range_funct3();
    int lat, wc; logic [1:0] op; logic [31:0] rd, bad; logic exc; logic [3:0] c;
    do_req(1'b0, 3'd2, 32'h3FC, 32'h0, lat, wc, op, rd, exc, c, bad);
    n_chk++; if (lat !== 2 || exc !== 1'b0) $display("FAIL lw_top_ok: got lat %0d exc %b want 2 0", lat, exc); else n_pass++;
    do_req(1'b0, 3'd2, 32'h400, 32'h0, lat, wc, op, rd, exc, c, bad);
    n_chk++; if (lat !== 1 || c !== 4'd5 || bad !== 32'h400) $display("FAIL lw_oor: got lat %0d cause %0d bad %h want 1 5 400", lat, c, bad); else n_pass++;
    do_req(1'b1, 3'd2, 32'hFFFFFFFC, 32'h1, lat, wc, op, rd, exc, c, bad);
    n_chk++; if (lat !== 1 || c !== 4'd7 || wc !== 0) $display("FAIL sw_oor: got lat %0d cause %0d we %0d want 1 7 0", lat, c, wc); else n_pass++;
    do_req(1'b0, 3'd3, 32'h0, 32'h0, lat, wc, op, rd, exc, c, bad);
    n_chk++; if (lat !== 1 || c !== 4'd2 || rd !== 32'h0) $display("FAIL ld_f3_illegal: got lat %0d cause %0d rdata %h want 1 2 0", lat, c, rd); else n_pass++;
  endtask

  task automatic test_flush();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h40; bus.req_wdata = 32'hAA;
    @(posedge clk); #1 bus.req_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    n_chk++; if (bus.mem_we !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0)
      $display("FAIL flush_gate: got we %b rv %b ready %b want 0 0 0", bus.mem_we, bus.resp_valid, bus.req_ready); else n_pass++;
    @(posedge clk); #1 flush = 1'b0;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd4; bus.req_addr = 32'h40;
    @(negedge clk);
    n_chk++; if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0) $display("FAIL flush_idle: got ready %b rv %b want 1 0", bus.req_ready, bus.resp_valid); else n_pass++;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 1'b0) $display("FAIL flush_b2b_access: got rv %b want 0", bus.resp_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'h0) $display("FAIL flush_no_write: got rv %b rdata %h want 1 0", bus.resp_valid, bus.resp_rdata); else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = 3'd2; bus.req_addr = 32'h10;
    @(posedge clk); #1 bus.req_funct3 = 3'd4; bus.req_addr = 32'h13;
    @(negedge clk);
    n_chk++; if (bus.req_ready !== 1'b0) $display("FAIL b2b_busy: got ready %b want 0", bus.req_ready); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDEADBEEF || bus.req_ready !== 1'b1)
      $display("FAIL b2b_first: got rv %b rdata %h ready %b want 1 deadbeef 1", bus.resp_valid, bus.resp_rdata, bus.req_ready); else n_pass++;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 1'b0) $display("FAIL b2b_access: got rv %b want 0", bus.resp_valid); else n_pass++;
    @(negedge clk);
    n_chk++; if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== 32'hDE) $display("FAIL b2b_second: got rv %b rdata %h want 1 de", bus.resp_valid, bus.resp_rdata); else n_pass++;
  endtask

  task automatic test_async_reset();
    int rv_cnt;
    rv_cnt = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = 3'd2;
    bus.req_addr = 32'h50; bus.req_wdata = 32'h12345678;
    @(posedge clk); #1 bus.req_valid = 1'b0;
    #2;
    n_chk++; if (bus.mem_we !== 1'b1) $display("FAIL arst_pre_we: got %b want 1", bus.mem_we); else n_pass++;
    rst_n = 1'b0; #1;
    n_chk++; if (bus.mem_we !== 1'b0) $display("FAIL arst_we_drop: got %b want 0", bus.mem_we); else n_pass++;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (bus.resp_valid) rv_cnt++; end
    n_chk++; if (rv_cnt !== 0 || bus.req_ready !== 1'b1) $display("FAIL arst_no_resp: got rv cycles %0d ready %b want 0 1", rv_cnt, bus.req_ready); else n_pass++;
    n_chk++; if ({ram[80], ram[81], ram[82], ram[83]} !== 32'h0) $display("FAIL arst_no_write: got %h want 0", {ram[80], ram[81], ram[82], ram[83]}); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_funct3 = 3'd0;
    bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    test_reset();
    test_store_load();
    test_extension();
    test_misalign();
    test_range_funct3();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
